// File: rtl/systolic_input_skew_if.sv
// Producer-side handshake into the systolic input skew stage.
// One vector per transfer, element i at bits [i*DATA_W +: DATA_W].
interface systolic_input_skew_if #(
  parameter int N      = 2,
  parameter int DATA_W = 8
) ();
  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_data;
  logic                in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/systolic_input_skew.sv
// Activation FIFO plus per-row delay line that feeds the PE array's
// left edge as a diagonal wavefront, with tile drain and done pulse.
module systolic_input_skew #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  systolic_input_skew_if.slave s_in,
  output logic [N*DATA_W-1:0] a_out,
  output logic [N-1:0]        a_valid,
  output logic                busy,
  output logic                done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = N * DATA_W + 1;
  localparam int SK_W  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [SK_W-1:0]  r_cnt;
  logic             r_done;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [ENT_W-1:0]    w_head;
  logic                w_head_last;
  logic [N*DATA_W-1:0] w_head_data;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = s_in.in_valid && !w_full;
  assign w_pop       = !w_empty && (r_state != S_DRAIN);
  assign w_head      = r_mem[r_rptr];
  assign w_head_last = w_head[ENT_W-1];
  assign w_head_data = w_head[N*DATA_W-1:0];

  assign s_in.in_ready = !w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {s_in.in_last, s_in.in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // DRAIN holds off pops until the last vector reaches row N-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_STREAM: begin
          if (w_pop) begin
            if (!w_head_last) begin
              r_state <= S_STREAM;
            end else if (N == 1) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
              r_cnt   <= SK_W'(N - 1);
            end
          end
        end
        S_DRAIN: begin
          r_cnt <= r_cnt - SK_W'(1);
          if (r_cnt == SK_W'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  for (genvar g = 0; g < N; g++) begin : g_row
    logic [DATA_W-1:0] r_d [g+1];
    logic [g:0]        r_v;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k <= g; k++) begin
          r_d[k] <= '0;
        end
        r_v <= '0;
      end else begin
        r_d[0] <= w_pop ? w_head_data[g*DATA_W +: DATA_W] : '0;
        r_v[0] <= w_pop;
        for (int k = 1; k <= g; k++) begin
          r_d[k] <= r_d[k-1];
          r_v[k] <= r_v[k-1];
        end
      end
    end

    assign a_out[g*DATA_W +: DATA_W] = r_d[g];
    assign a_valid[g]                = r_v[g];
  end

endmodule
